mul_share_ctrl: RTL and testbench

- Time-multiplexes one external combinational 8x8 unsigned multiplier (ports a, b, mul) between NREQ requesters.
- Uses a round-robin arbiter, operand registers, and a programmable settle-wait counter, so CGP-evolved multipliers of arbitrary depth can be used as multicycle paths.
- Returns each product with the requester ID over a valid/ready response channel.
- Sits between client logic and the evolved multiplier netlist.

---
 rtl/mul_share_ctrl.sv | 140 ++++++++++++++
 tb/tb_mul_share_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one combinational 8x8 multiplier
//
// Purpose: grants one of NREQ requesters at a time, drives its operands to an
// external multiplier for MUL_LAT cycles, then registers the product and
// returns it with the requester index over a valid/ready response channel.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/req_a/req_b    per-requester request, operands packed 8 bits each
//   req_ready                one-hot grant, only ever asserted in IDLE
//   mul_a/mul_b/mul_p        operand outputs and product input of the multiplier
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_product       owner index and registered product
//   busy                     high whenever a transaction is in flight
module mul_share_ctrl #(
    parameter int  NREQ    = 4,
    parameter int  MUL_LAT = 2,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_product,
    output logic              busy
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_mul_a;
    logic [7:0]      r_mul_b;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [15:0]     r_rsp_product;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_win;
    logic            w_found;
    logic            w_hs;
    logic [IDW-1:0]  w_ptr_nxt;
    int              w_idx;

    // Round-robin search starting at the pointer; the first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
        w_grant[w_win] = w_found;
    end

    // Grant is only visible in IDLE and is suppressed combinationally in reset.
    assign req_ready = (r_state == S_IDLE && rst_n) ? w_grant : '0;
    assign w_hs      = |(req_valid & req_ready);
    assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == CW'(1)) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_id          <= '0;
            r_cnt         <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_mul_a <= req_a[8*w_win +: 8];
                        r_mul_b <= req_b[8*w_win +: 8];
                        r_id    <= w_win;
                        r_ptr   <= w_ptr_nxt;
                        r_cnt   <= CW'(MUL_LAT);
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Operands have now been stable for MUL_LAT cycles.
                    if (r_cnt == CW'(1)) begin
                        r_rsp_product <= mul_p;
                        r_rsp_id      <= r_id;
                        r_rsp_valid   <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - scoreboard bench for mul_share_ctrl
module tb_mul_share_ctrl;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [NREQ-1:0] req_ready;
    logic [7:0]      mul_a;
    logic [7:0]      mul_b;
    logic [15:0]     mul_p;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_product;
    logic            busy;

    mul_share_ctrl #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Multiplier model: the product is garbage until operands have been stable MUL_LAT cycles.
    logic [15:0] prev_ab = 16'h0;
    int          stab    = 0;
    always @(negedge clk) begin
        if ({mul_a, mul_b} != prev_ab) begin
            prev_ab = {mul_a, mul_b};
            stab    = 1;
        end else if (stab < 1000) begin
            stab++;
        end
    end
    assign mul_p = (stab >= MUL_LAT) ? 16'(mul_a) * 16'(mul_b) : 16'hDEAD;

    typedef struct {
        logic [1:0] id;
        logic [7:0] a;
        logic [7:0] b;
    } txn_t;

    txn_t       sb[$];
    int         m_st    = 0;
    int         m_cnt   = 0;
    logic [1:0] m_ptr   = 2'd0;
    bit         m_clean = 1'b1;
    int         m_hs    = 0;
    int         d_rsp   = 0;
    int         cyc     = 0;

    always @(posedge clk) cyc++;

    function automatic logic [3:0] rr(input logic [1:0] p, input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int ix;
            ix = (int'(p) + k) % NREQ;
            if (v[ix]) return 4'(1 << ix);
        end
        return 4'b0;
    endfunction

    // Reference model: checks every cycle, then advances to the next-cycle state.
    always @(negedge clk) begin
        logic [3:0]  eg;
        logic [15:0] ep;
        int          gi;
        if (!rst_n) begin
            chk("rdy_in_reset", 32'(req_ready), 32'h0);
            m_st    = 0;
            m_ptr   = 2'd0;
            m_clean = 1'b1;
            sb.delete();
        end else begin
            eg = (m_st == 0) ? rr(m_ptr, req_valid) : 4'b0;
            chk("req_ready", 32'(req_ready), 32'(eg));
            chk("busy", 32'(busy), 32'(m_st != 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
            if (m_clean) begin
                chk("rst_mul_a", 32'(mul_a), 32'h0);
                chk("rst_mul_b", 32'(mul_b), 32'h0);
                chk("rst_rsp_id", 32'(rsp_id), 32'h0);
                chk("rst_rsp_product", 32'(rsp_product), 32'h0);
            end
            if (m_st != 0) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'h0, 32'h1);
                end else begin
                    chk("hold_mul_a", 32'(mul_a), 32'(sb[0].a));
                    chk("hold_mul_b", 32'(mul_b), 32'(sb[0].b));
                    if (m_st == 2) begin
                        ep = 16'(sb[0].a) * 16'(sb[0].b);
                        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                        chk("rsp_product", 32'(rsp_product), 32'(ep));
                    end
                end
            end
            if (rsp_valid && rsp_ready) d_rsp++;
            case (m_st)
                0: if (eg != 4'b0) begin
                    gi = 0;
                    for (int k = 0; k < NREQ; k++) if (eg[k]) gi = k;
                    sb.push_back('{id: 2'(gi), a: req_a[8*gi +: 8], b: req_b[8*gi +: 8]});
                    m_ptr   = 2'(gi + 1);
                    m_st    = 1;
                    m_cnt   = MUL_LAT;
                    m_clean = 1'b0;
                    m_hs++;
                end
                1: if (m_cnt == 1) m_st = 2; else m_cnt--;
                2: if (rsp_ready) begin
                    void'(sb.pop_front());
                    m_st = 0;
                end
                default: m_st = 0;
            endcase
        end
    end

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'h1);
    endtask

    // Single request from requester id, checked against constant expectations.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] ep, input string tag);
        bit got;
        int n;
        @(posedge clk); #1;
        req_valid = 4'(1 << id);
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        rsp_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        chk({tag, "_gnt"}, 32'(got), 32'h1);
        chk({tag, "_rdy"}, 32'(req_ready), 32'(1 << id));
        @(posedge clk); #1;
        req_valid = 4'b0;
        got = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1'b1;
        end
        chk({tag, "_lat"}, 32'(n), 32'(MUL_LAT + 1));
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_prod"}, 32'(rsp_product), 32'(ep));
        @(posedge clk); #1;
    endtask

    initial begin
        int          last;
        bit          got;
        logic [15:0] hp;
        int          hs0;
        int          rsp0;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // All requesters held high from reset: strict rotation, one grant per MUL_LAT+2.
        last = 0;
        for (int k = 0; k < 6; k++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (req_ready != 4'b0) got = 1'b1;
            end
            chk("rr_order", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_interval", 32'(cyc - last), 32'(MUL_LAT + 2));
            last = cyc;
        end
        @(posedge clk); #1;
        req_valid = 4'b0;
        wait_idle("rr_drain");

        issue(2, 8'd13, 8'd11, 16'd143, "basic");
        issue(0, 8'd255, 8'd255, 16'hFE01, "max");
        issue(3, 8'd0, 8'd200, 16'd0, "zero");
        issue(1, 8'd1, 8'd255, 16'd255, "one");
        issue(2, 8'd128, 8'd2, 16'd256, "carry");

        // Backpressure in RESP.
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_a[15:8] = 8'd200;
        req_b[15:8] = 8'd3;
        rsp_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        chk("bp_gnt", 32'(got), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'hF;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        hp = rsp_product;
        chk("bp_prod", 32'(hp), 32'd600);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold", 32'(rsp_product), 32'(hp));
            chk("bp_id", 32'(rsp_id), 32'h1);
            chk("bp_rdy", 32'(req_ready), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
        end
        @(posedge clk); #1;
        req_valid = 4'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", 32'(busy), 32'h0);

        // Reset during WAIT discards the transaction and the pointer.
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_a[15:8] = 8'd7;
        req_b[15:8] = 8'd9;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        chk("rw_gnt", 32'(got), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rw_busy", 32'(busy), 32'h0);
        chk("rw_mul_a", 32'(mul_a), 32'h0);
        chk("rw_mul_b", 32'(mul_b), 32'h0);
        chk("rw_grant0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'b0;
        wait_idle("rw_drain");

        // Random traffic with random backpressure.
        hs0  = m_hs;
        rsp0 = d_rsp;
        for (int c = 0; c < 4000 && (m_hs - hs0) < 100; c++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
        end
        chk("rand_count", 32'(m_hs - hs0 >= 100), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'b0;
        rsp_ready = 1'b1;
        wait_idle("rand_drain");
        repeat (2) @(negedge clk);
        chk("rand_no_loss", 32'(d_rsp - rsp0), 32'(m_hs - hs0));
        chk("rand_sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
